// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg -- shared types and helpers for the multiply/divide unit.
//   mdu_op_e    : RV32M funct3 encodings
//   mdu_state_e : sequencer states
//   most_neg()  : most-negative two's-complement value for a given width
// -----------------------------------------------------------------------------
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

  localparam int unsigned MDU_MAX_XLEN = 128;

  // Caller truncates to its own width.
  function automatic logic [MDU_MAX_XLEN-1:0] most_neg(input int unsigned xlen);
    logic [MDU_MAX_XLEN-1:0] v;
    v = '0;
    v[xlen-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// -----------------------------------------------------------------------------
// mdu_div_iter -- one restoring-division step (combinational).
//   i_rem     : partial remainder (always < divisor)
//   i_dbit    : next dividend bit shifted in
//   i_divisor : divisor magnitude
//   o_rem     : next partial remainder
//   o_qbit    : quotient bit produced by this step
// -----------------------------------------------------------------------------
module mdu_div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_dbit,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qbit
);

  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  assign w_shift = {i_rem, i_dbit};
  assign w_diff  = w_shift - {1'b0, i_divisor};

  // w_shift < 2*divisor, so the top bit of the difference is a clean borrow flag.
  assign o_qbit = ~w_diff[XLEN];
  assign o_rem  = o_qbit ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];

endmodule

// File: rtl/mdu.sv
// -----------------------------------------------------------------------------
// mdu -- multi-cycle RV32M multiply/divide unit (radix-2 shift-add / restoring
// shift-subtract). Optional macro MDU_FAST_MUL_EN: single-cycle multiplies.
//   clk, rst_n     : clock, synchronous active-low reset
//   start, funct3  : request and operation (sampled when not busy)
//   rs1, rs2       : operands (dividend / divisor for DIV/REM)
//   busy           : operation in flight, new start ignored
//   valid          : one-cycle strobe, rd holds a new result
//   rd, z          : result and registered rd==0 flag
// -----------------------------------------------------------------------------
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] rd,
  output logic            z
);

  localparam int unsigned   CW       = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MOST_NEG = XLEN'(most_neg(XLEN));

  mdu_state_e        r_state, w_next;
  mdu_op_e           r_op;
  logic [CW-1:0]     r_cnt;
  logic              r_neg;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_rd;
  logic              r_z;

  mdu_op_e           w_op;
  logic              w_accept, w_is_div, w_sa, w_sb, w_neg;
  logic              w_div0, w_ovf, w_bypass, w_fast_hit;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_spec_res, w_fast_res, w_bypass_res;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN-1:0]   w_div_rem, w_div_sel, w_fix_res;
  logic              w_qbit;
  logic [2*XLEN-1:0] w_step, w_prod;

  assign w_op     = mdu_op_e'(funct3);
  assign w_accept = start & ((r_state == IDLE) | (r_state == DONE));
  assign w_is_div = funct3[2];

  // Operand signedness per op; MUL is sign-agnostic in its low half.
  always_comb begin
    w_sa = 1'b0;
    w_sb = 1'b0;
    case (w_op)
      OP_MULH, OP_DIV, OP_REM: begin
        w_sa = rs1[XLEN-1];
        w_sb = rs2[XLEN-1];
      end
      OP_MULHSU: w_sa = rs1[XLEN-1];
      default: ;
    endcase
  end

  assign w_mag_a = w_sa ? -rs1 : rs1;
  assign w_mag_b = w_sb ? -rs2 : rs2;
  // Remainder follows the dividend sign; products/quotients the sign product.
  assign w_neg   = (w_op == OP_REM) ? w_sa : (w_sa ^ w_sb);

  assign w_div0 = w_is_div & (rs2 == '0);
  assign w_ovf  = ((w_op == OP_DIV) | (w_op == OP_REM)) & (rs1 == MOST_NEG) & (rs2 == '1);

  always_comb begin
    w_spec_res = '0;
    if (w_div0)     w_spec_res = funct3[1] ? rs1 : '1;
    else if (w_ovf) w_spec_res = funct3[1] ? '0  : rs1;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] w_ea, w_eb, w_fp;
  assign w_ea       = {{XLEN{w_sa}}, rs1};
  assign w_eb       = {{XLEN{w_sb}}, rs2};
  assign w_fp       = w_ea * w_eb;
  assign w_fast_hit = ~w_is_div;
  assign w_fast_res = (w_op == OP_MUL) ? w_fp[XLEN-1:0] : w_fp[2*XLEN-1:XLEN];
`else
  assign w_fast_hit = 1'b0;
  assign w_fast_res = '0;
`endif

  assign w_bypass     = w_div0 | w_ovf | w_fast_hit;
  assign w_bypass_res = w_fast_hit ? w_fast_res : w_spec_res;

  // r_acc doubles as {hi, lo} product accumulator and {remainder, dividend/quotient}.
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);

  mdu_div_iter #(.XLEN(XLEN)) u_div_iter (
    .i_rem     (r_acc[2*XLEN-1:XLEN]),
    .i_dbit    (r_acc[XLEN-1]),
    .i_divisor (r_b),
    .o_rem     (w_div_rem),
    .o_qbit    (w_qbit)
  );

  assign w_step = r_op[2] ? {w_div_rem, r_acc[XLEN-2:0], w_qbit}
                          : {w_mul_sum, r_acc[XLEN-1:1]};

  assign w_prod    = r_neg ? -r_acc : r_acc;
  assign w_div_sel = r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];

  always_comb begin
    w_fix_res = '0;
    case (r_op)
      OP_MUL:                       w_fix_res = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
      default:                      w_fix_res = r_neg ? -w_div_sel : w_div_sel;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = w_accept ? (w_bypass ? DONE : CALC) : IDLE;
      CALC:       if (r_cnt == CW'(1)) w_next = FIX;
      FIX:        w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op  <= OP_MUL;
      r_neg <= 1'b0;
      r_acc <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_rd  <= '0;
      r_z   <= 1'b1;
    end else if (w_accept) begin
      r_op  <= w_op;
      r_neg <= w_neg;
      r_acc <= {{XLEN{1'b0}}, w_mag_a};
      r_b   <= w_mag_b;
      r_cnt <= w_bypass ? '0 : CW'(XLEN);
      if (w_bypass) begin
        r_rd <= w_bypass_res;
        r_z  <= (w_bypass_res == '0);
      end
    end else if (r_state == CALC) begin
      r_acc <= w_step;
      r_cnt <= r_cnt - CW'(1);
    end else if (r_state == FIX) begin
      r_rd <= w_fix_res;
      r_z  <= (w_fix_res == '0);
    end
  end

  assign busy  = (r_state == CALC) | (r_state == FIX);
  assign valid = (r_state == DONE);
  assign rd    = r_rd;
  assign z     = r_z;

endmodule

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit implementing the RV32M `funct3` operations beside the single-cycle integer ALU in the execute stage. The unit is parametrised in operand width, latches operands on a start pulse, iterates a radix-2 shift-add/shift-subtract datapath, and returns a result with a one-cycle valid strobe plus zero flag. It provides the multi-cycle, handshaked behaviour the combinational ALU lacks, so the pipeline can stall on `busy`.

## Interface
- `XLEN`, 32, operand and result width (≥ 8, power of two)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  request; sampled only when `busy`=0
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1`, `rs2`  in  XLEN  operands (dividend/divisor for DIV/REM)
- `busy`  out  1  operation in flight; new `start` ignored
- `valid`  out  1  one-cycle strobe: `rd` holds a new result
- `rd`  out  XLEN  result; held until the next accepted start completes
- `z`  out  1  registered, `rd`==0

## Operation
- FSM states: IDLE, CALC, FIX, DONE. Accept = `start`=1 in IDLE or DONE (back-to-back allowed).
- Accept: latch `funct3`, record operand signs, load magnitudes (|x| for signed operands per op: MUL/MULHU unsigned-agnostic, MULH both signed, MULHSU `rs1` signed/`rs2` unsigned, DIV/REM signed, DIVU/REMU unsigned); counter ← XLEN; state → CALC.
- CALC: one iteration per cycle (mul: add-shift into 2·XLEN accumulator; div: restoring shift-subtract producing quotient bit). Counter reaches 0 → FIX.
- FIX: negate product/quotient/remainder as required (remainder takes dividend sign); select low half (MUL) or high half (MULH*) or quotient/remainder; write `rd`, `z`; → DONE.
- DONE: `valid`=1 for this cycle only; → IDLE unless a new start is accepted.
- Division special cases bypass CALC/FIX (accept → DONE directly): divide by zero → DIV/DIVU `rd` = all ones, REM/REMU `rd` = `rs1`; signed overflow (DIV/REM, `rs1`=−2^(XLEN−1), `rs2`=−1) → DIV `rd` = `rs1`, REM `rd` = 0.
- All arithmetic modulo 2^XLEN; no exceptions raised.
- `start` while `busy`=1: ignored, no state or output change.

## Timing
- Reset (edge with `rst_n`=0): state IDLE, `busy`=0, `valid`=0, `rd`=0, `z`=1, counter 0. Reset mid-operation aborts; no `valid` issued.
- `busy`=1 in CALC and FIX; 0 in IDLE and DONE.
- Accept at edge E0; normal ops: `valid` high in the cycle after edge E0+XLEN+1 (33 edges for XLEN=32).
- Division special cases: `valid` high in the cycle after E0 (latency 1).
- `rd`/`z` change only on the edge entering DONE.

## Configuration
- `MDU_FAST_MUL_EN` defined: MUL/MULH/MULHSU/MULHU computed with a single-cycle 2·XLEN-bit signed-extended product; accept → DONE, latency 1, `busy` never asserted for multiplies.
- Undefined: multiplies use the iterative CALC/FIX path, latency XLEN+1. Division always iterative.

## Structure
- Package `mdu_pkg`: `mdu_op_e` enum for `funct3` encodings, `mdu_state_e` (IDLE/CALC/FIX/DONE), helper constant for the most-negative value as a function of XLEN.
- Sub-module `mdu_div_iter`: one restoring-division step (partial remainder, divisor → next remainder, quotient bit), instanced once in `mdu`.

## Test plan
- Reset mid-DIV (assert `rst_n`=0 at cycle 10 of CALC) → `busy`=0, `valid`=0, `rd`=0, `z`=1 next cycle; no later `valid`.
- DIV `rs1`=−20, `rs2`=3 → `rd`=−6 (0xFFFFFFFA), `valid` exactly 33 cycles after accept; REM same operands → `rd`=−2.
- DIVU `rs2`=0, `rs1`=0x1234 → `rd`=0xFFFFFFFF latency 1; REMU → `rd`=0x1234; DIV 0x80000000/−1 → `rd`=0x80000000, REM → 0, `z`=1.
- MULH 0x80000000·0x80000000 → `rd`=0x40000000; MULHSU −1·0xFFFFFFFF → `rd`=0xFFFFFFFF; MULHU same → 0xFFFFFFFE; MUL 7·−3 → 0xFFFFFFEB.
- `start` pulsed every cycle during a DIV → only the first accepted; start in DONE cycle accepted back-to-back, second `valid` follows correct latency.
- Build with `MDU_FAST_MUL_EN` and XLEN=64: MUL 3·5 → `rd`=15, `valid` one cycle after accept, `busy` stays 0.
